// File: rtl/garduino_pwm_pkg.sv
// Shared constants for the garduino PWM peripheral: register word addresses,
// channel limit and a helper to form per-channel addresses.
package garduino_pwm_pkg;

    localparam int MAX_CH = 8;

    localparam logic [4:0] ADDR_ENABLE      = 5'd0;
    localparam logic [4:0] ADDR_PERIOD      = 5'd1;
    localparam logic [4:0] ADDR_PRESCALE    = 5'd2;
    localparam logic [4:0] ADDR_STATUS      = 5'd3;
    localparam logic [4:0] ADDR_TARGET_BASE = 5'd8;
    localparam logic [4:0] ADDR_CUR_BASE    = 5'd16;

    function automatic logic [4:0] ch_addr(input logic [4:0] base, input int ch);
        return base | 5'(ch);
    endfunction

endpackage

// File: rtl/garduino_pwm_channel.sv
// One PWM channel: target/current duty storage, boundary update and compare.
// Define GARDUINO_PWM_RAMP_EN to slew the current duty by 1 per period.
module garduino_pwm_channel
    import garduino_pwm_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             boundary,
    input  logic [CNT_W-1:0] cnt,
    input  logic             enable,
    output logic [CNT_W-1:0] target_duty,
    output logic [CNT_W-1:0] cur_duty,
    output logic             pwm,
    output logic             status
);

    logic [CNT_W-1:0] target_reg;
    logic [CNT_W-1:0] cur_reg;
    logic [CNT_W-1:0] cur_next;
    logic             pwm_reg;

    always_comb begin
        cur_next = cur_reg;
`ifdef GARDUINO_PWM_RAMP_EN
        // Soft start: one step per period toward the target, never past it.
        if (cur_reg < target_reg) begin
            cur_next = cur_reg + 1'b1;
        end else if (cur_reg > target_reg) begin
            cur_next = cur_reg - 1'b1;
        end
`else
        cur_next = target_reg;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_reg <= '0;
            cur_reg    <= '0;
            pwm_reg    <= 1'b0;
        end else begin
            if (wr_en) begin
                target_reg <= wr_data;
            end
            if (boundary) begin
                cur_reg <= cur_next;
            end
            pwm_reg <= enable && (cnt < cur_reg);
        end
    end

    assign target_duty = target_reg;
    assign cur_duty    = cur_reg;
    assign pwm         = pwm_reg;
    assign status      = (cur_reg != target_reg);

endmodule

// File: rtl/garduino_pwm_pio.sv
// Avalon-MM multi-channel PWM peripheral with prescaler and shadowed period.
// Define GARDUINO_PWM_RAMP_EN to enable soft-start duty slewing in each channel.
module garduino_pwm_pio
    import garduino_pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 10,
    parameter int PRE_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    logic [NUM_CH-1:0] enable_reg;
    logic [CNT_W-1:0]  period_reg;
    logic [CNT_W-1:0]  active_period_reg;
    logic [PRE_W-1:0]  prescale_reg;
    logic [PRE_W-1:0]  pre_cnt_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic              wr;
    logic              tick;
    logic              boundary;
    logic              writedata_unused;

    logic [CNT_W-1:0]  target_arr [NUM_CH];
    logic [CNT_W-1:0]  cur_arr    [NUM_CH];
    logic [NUM_CH-1:0] status_vec;

    assign wr               = chipselect && !write_n;
    assign writedata_unused = ^writedata;

    // >= rather than == so lowering PRESCALE below the running count
    // wraps immediately instead of running out to the register limit.
    assign tick        = (pre_cnt_reg >= prescale_reg);
    assign boundary    = tick && (cnt_reg >= active_period_reg);
    assign period_tick = boundary;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_reg        <= '0;
            period_reg        <= '1;
            active_period_reg <= '1;
            prescale_reg      <= '0;
            pre_cnt_reg       <= '0;
            cnt_reg           <= '0;
        end else begin
            if (wr && address == ADDR_ENABLE) begin
                enable_reg <= writedata[NUM_CH-1:0];
            end
            if (wr && address == ADDR_PERIOD) begin
                period_reg <= writedata[CNT_W-1:0];
            end
            if (wr && address == ADDR_PRESCALE) begin
                prescale_reg <= writedata[PRE_W-1:0];
            end

            if (tick) begin
                pre_cnt_reg <= '0;
            end else begin
                pre_cnt_reg <= pre_cnt_reg + 1'b1;
            end

            // A PERIOD write on the boundary cycle lands in the shadow after
            // this copy, so it takes effect one period later.
            if (boundary) begin
                cnt_reg           <= '0;
                active_period_reg <= period_reg;
            end else if (tick) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            garduino_pwm_channel #(
                .CNT_W(CNT_W)
            ) u_channel (
                .clk        (clk),
                .reset      (reset),
                .wr_en      (wr && (address == ch_addr(ADDR_TARGET_BASE, gi))),
                .wr_data    (writedata[CNT_W-1:0]),
                .boundary   (boundary),
                .cnt        (cnt_reg),
                .enable     (enable_reg[gi]),
                .target_duty(target_arr[gi]),
                .cur_duty   (cur_arr[gi]),
                .pwm        (pwm_out[gi]),
                .status     (status_vec[gi])
            );
        end
    endgenerate

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_ENABLE:   readdata[NUM_CH-1:0] = enable_reg;
            ADDR_PERIOD:   readdata[CNT_W-1:0]  = period_reg;
            ADDR_PRESCALE: readdata[PRE_W-1:0]  = prescale_reg;
            ADDR_STATUS:   readdata[NUM_CH-1:0] = status_vec;
            default:       readdata = '0;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (address == ch_addr(ADDR_TARGET_BASE, i)) begin
                readdata[CNT_W-1:0] = target_arr[i];
            end
            if (address == ch_addr(ADDR_CUR_BASE, i)) begin
                readdata[CNT_W-1:0] = cur_arr[i];
            end
        end
    end

endmodule

// File: tb/tb_garduino_pwm_pio.sv
// Directed self-checking bench for garduino_pwm_pio (default parameters).
// Expectations follow the GARDUINO_PWM_RAMP_EN setting of the build.
`timescale 1ns/1ps
module tb_garduino_pwm_pio;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 10;
    localparam int PRE_W  = 8;

`ifdef GARDUINO_PWM_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [4:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_tick;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    garduino_pwm_pio #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .pwm_out    (pwm_out),
        .period_tick(period_tick)
    );

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        #1;
        d = readdata;
    endtask

    // Negedges stepped until period_tick is seen (returns limit on timeout).
    task automatic wait_tick(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!period_tick && cycles < limit);
    endtask

    task automatic settle();
        int c;
        for (int i = 0; i < 16; i++) wait_tick(1100, c);
    endtask

    task automatic test_reset();
        logic [4:0]  addrs [14] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd11,
                                    5'd12, 5'd16, 5'd19, 5'd20, 5'd24, 5'd31};
        logic [31:0] exps  [14] = '{32'd0, 32'd1023, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                                    32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        logic [31:0] r;
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (pwm_out !== '0) begin bad++; $display("FAIL reset_pwm: got %0h want 0", pwm_out); end
        total++;
        if (period_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %0b want 0", period_tick); end
        @(negedge clk);
        reset = 1'b0;
        // Writes to RO / unmapped / out-of-range channel addresses must be dropped.
        bus_write(5'd3, 32'hFF);
        bus_write(5'd4, 32'h55);
        bus_write(5'd12, 32'h5);
        bus_write(5'd16, 32'h5);
        for (int i = 0; i < 14; i++) begin
            bus_read(addrs[i], r);
            total++;
            if (r !== exps[i]) begin
                bad++;
                $display("FAIL reset_read[%0d]: got %0h want %0h", addrs[i], r, exps[i]);
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_default_period();
        int c;
        int high;
        wait_tick(1100, c);
        c = 0; high = 0;
        do begin
            @(negedge clk);
            c++;
            if (pwm_out != '0) high++;
        end while (!period_tick && c < 1100);
        total++;
        if (c !== 1024) begin bad++; $display("FAIL default_period: got %0d want 1024", c); end
        total++;
        if (high !== 0) begin bad++; $display("FAIL default_pwm_low: got %0d high cycles want 0", high); end
        $display("test_default_period: interval=%0d", c);
    endtask

    task automatic test_basic();
        logic [9:0]  pat;
        logic [31:0] r;
        int c;
        int others;
        bus_write(5'd1, 32'd9);
        bus_write(5'd8, 32'd3);
        bus_write(5'd0, 32'd1);
        settle();
        others = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            pat[k] = pwm_out[0];
            if (pwm_out[NUM_CH-1:1] != '0) others++;
        end
        total++;
        if (pat !== 10'h00E) begin bad++; $display("FAIL basic_pattern: got %b want %b", pat, 10'h00E); end
        total++;
        if (period_tick !== 1'b1) begin bad++; $display("FAIL basic_tick_phase: got %0b want 1", period_tick); end
        total++;
        if (others !== 0) begin bad++; $display("FAIL basic_other_ch: got %0d want 0", others); end
        wait_tick(100, c);
        total++;
        if (c !== 10) begin bad++; $display("FAIL basic_period: got %0d want 10", c); end
        bus_read(5'd16, r);
        total++;
        if (r !== 32'd3) begin bad++; $display("FAIL basic_cur: got %0d want 3", r); end
        $display("test_basic: pattern=%b interval=%0d", pat, c);
    endtask

    task automatic test_duty_bounds();
        logic [31:0] duties [2] = '{32'd0, 32'd10};
        logic [31:0] r;
        int c;
        int high;
        for (int j = 0; j < 2; j++) begin
            wait_tick(100, c);
            bus_write(5'd8, duties[j]);
            bus_read(5'd3, r);
            total++;
            if (r !== 32'd1) begin bad++; $display("FAIL bounds_status_pending[%0d]: got %0h want 1", duties[j], r); end
            settle();
            high = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (pwm_out[0]) high++;
            end
            total++;
            if (high !== int'(duties[j])) begin
                bad++; $display("FAIL bounds_high[%0d]: got %0d want %0d", duties[j], high, duties[j]);
            end
            bus_read(5'd16, r);
            total++;
            if (r !== duties[j]) begin bad++; $display("FAIL bounds_cur[%0d]: got %0d want %0d", duties[j], r, duties[j]); end
            bus_read(5'd3, r);
            total++;
            if (r !== 32'd0) begin bad++; $display("FAIL bounds_status_clear[%0d]: got %0h want 0", duties[j], r); end
            $display("test_duty_bounds: duty=%0d high=%0d/10", duties[j], high);
        end
    endtask

    task automatic test_enable();
        int c;
        wait_tick(100, c);
        bus_write(5'd0, 32'd0);
        @(negedge clk);
        total++;
        if (pwm_out[0] !== 1'b0) begin bad++; $display("FAIL enable_off: got %0b want 0", pwm_out[0]); end
        bus_write(5'd0, 32'd1);
        @(negedge clk);
        total++;
        if (pwm_out[0] !== 1'b1) begin bad++; $display("FAIL enable_on: got %0b want 1", pwm_out[0]); end
        wait_tick(100, c);
        total++;
        if (c !== 4) begin bad++; $display("FAIL enable_counter_kept: got %0d want 4", c); end
        $display("test_enable: remaining=%0d", c);
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int c;
        wait_tick(100, c);
        chipselect = 1'b1; write_n = 1'b0; address = 5'd8; writedata = 32'd7;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        address = 5'd16;
        #1;
        total++;
        if (readdata !== 32'd10) begin bad++; $display("FAIL b2b_cur_held: got %0d want 10", readdata); end
        address = 5'd3;
        #1;
        total++;
        if (readdata !== 32'd1) begin bad++; $display("FAIL b2b_status: got %0h want 1", readdata); end
        wait_tick(100, c);
        bus_read(5'd16, r);
        total++;
        if (r !== (RAMP ? 32'd9 : 32'd7)) begin
            bad++; $display("FAIL b2b_cur_next: got %0d want %0d", r, RAMP ? 9 : 7);
        end
        $display("test_back_to_back: cur=%0d", r);
    endtask

    task automatic test_period_change();
        logic [31:0] vals  [3] = '{32'd9, 32'd4, 32'd9};
        int          first [3] = '{5, 10, 5};
        int          second[3] = '{10, 5, 10};
        logic [31:0] r;
        int c;
        int c2;
        wait_tick(100, c);
        chipselect = 1'b1; write_n = 1'b0; address = 5'd1; writedata = 32'd4;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        wait_tick(100, c);
        total++;
        if (c + 1 !== 10) begin bad++; $display("FAIL period_boundary_first: got %0d want 10", c + 1); end
        wait_tick(100, c);
        total++;
        if (c !== 5) begin bad++; $display("FAIL period_boundary_second: got %0d want 5", c); end
        for (int j = 0; j < 3; j++) begin
            wait_tick(100, c);
            bus_write(5'd1, vals[j]);
            wait_tick(100, c);
            wait_tick(100, c2);
            total++;
            if (c + 2 !== first[j]) begin
                bad++; $display("FAIL period_mid_first[%0d]: got %0d want %0d", j, c + 2, first[j]);
            end
            total++;
            if (c2 !== second[j]) begin
                bad++; $display("FAIL period_mid_second[%0d]: got %0d want %0d", j, c2, second[j]);
            end
            $display("test_period_change: write %0d -> %0d then %0d", vals[j], c + 2, c2);
        end
        bus_read(5'd1, r);
        total++;
        if (r !== 32'd9) begin bad++; $display("FAIL period_read: got %0d want 9", r); end
    endtask

    task automatic test_prescale();
        logic [31:0] r;
        int c;
        bus_write(5'd2, 32'd1);
        wait_tick(100, c);
        wait_tick(100, c);
        total++;
        if (c !== 20) begin bad++; $display("FAIL prescale1_period: got %0d want 20", c); end
        bus_read(5'd2, r);
        total++;
        if (r !== 32'd1) begin bad++; $display("FAIL prescale_read: got %0d want 1", r); end
        bus_write(5'd2, 32'd0);
        wait_tick(100, c);
        wait_tick(100, c);
        total++;
        if (c !== 10) begin bad++; $display("FAIL prescale0_period: got %0d want 10", c); end
        $display("test_prescale: restored interval=%0d", c);
    endtask

    task automatic test_ramp();
        logic [31:0] r;
        logic [31:0] exp_cur;
        logic [31:0] exp_st;
        int c;
        bus_write(5'd8, 32'd0);
        settle();
        bus_read(5'd16, r);
        total++;
        if (r !== 32'd0) begin bad++; $display("FAIL ramp_start: got %0d want 0", r); end
        wait_tick(100, c);
        bus_write(5'd8, 32'd5);
        for (int k = 1; k <= 6; k++) begin
            wait_tick(100, c);
            exp_cur = RAMP ? 32'((k > 5) ? 5 : k) : 32'd5;
            exp_st  = (RAMP && k < 5) ? 32'd1 : 32'd0;
            bus_read(5'd16, r);
            total++;
            if (r !== exp_cur) begin bad++; $display("FAIL ramp_cur[%0d]: got %0d want %0d", k, r, exp_cur); end
            bus_read(5'd3, r);
            total++;
            if (r !== exp_st) begin bad++; $display("FAIL ramp_status[%0d]: got %0h want %0h", k, r, exp_st); end
            $display("test_ramp: boundary %0d cur_expected=%0d", k, exp_cur);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        bus_write(5'd8, 32'd10);
        settle();
        @(negedge clk);
        total++;
        if (pwm_out[0] !== 1'b1) begin bad++; $display("FAIL rstmid_pre_high: got %0b want 1", pwm_out[0]); end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (pwm_out !== '0) begin bad++; $display("FAIL rstmid_async_low: got %0h want 0", pwm_out); end
        total++;
        if (period_tick !== 1'b0) begin bad++; $display("FAIL rstmid_tick: got %0b want 0", period_tick); end
        @(negedge clk);
        reset = 1'b0;
        bus_read(5'd8, r);
        total++;
        if (r !== 32'd0) begin bad++; $display("FAIL rstmid_target: got %0d want 0", r); end
        bus_read(5'd16, r);
        total++;
        if (r !== 32'd0) begin bad++; $display("FAIL rstmid_cur: got %0d want 0", r); end
        bus_read(5'd0, r);
        total++;
        if (r !== 32'd0) begin bad++; $display("FAIL rstmid_enable: got %0h want 0", r); end
        bus_read(5'd1, r);
        total++;
        if (r !== 32'd1023) begin bad++; $display("FAIL rstmid_period: got %0d want 1023", r); end
        $display("test_reset_mid: done");
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_basic();
        test_duty_bounds();
        test_enable();
        test_back_to_back();
        test_period_change();
        test_prescale();
        test_ramp();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
